score_keeper: RTL
=================

Name: score_keeper

Overview:
- Producer side of the score interface: tracks game state, detects the bird clearing each pipe, and drives score1/score2 to the score display block.
- Also keeps a BCD copy of the total and a session high score for the HUD.
- Sits between the game-logic blocks (bird, pipes, collision) and the score renderer.
- Runs at pixel clock. Score updates once per frame tick.

Parameters:
- PIPE_W, 10'd60: pipe width in pixels. A pipe's right edge is pipe_x + PIPE_W.
- MAX_SCORE, 7'd99: saturation limit of score1 + score2. This is the two-digit display range.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset.
- frame_clk  input  1  vsync-rate level signal, synchronous to Clk. Its rising edge is the frame tick.
- start  input  1  start/restart request, level-sampled.
- dead  input  1  collision indication from collision logic, level-sampled.
- bird_x  input  10  bird left-edge X.
- pipe1_x  input  10  pipe 1 left-edge X.
- pipe2_x  input  10  pipe 2 left-edge X.
- score1  output  7  pipes cleared via pipe 1.
- score2  output  7  pipes cleared via pipe 2.
- ones  output  4  BCD ones digit of score1 + score2.
- tens  output  4  BCD tens digit of score1 + score2.
- high_score  output  7  best total this power-on session.
- game_state  output  2  IDLE = 2'b00, PLAYING = 2'b01, DEAD = 2'b10.

Behaviour:
- Reset low, asynchronous:
  - game_state = IDLE.
  - score1, score2, ones, tens, high_score = 0.
  - Arm flags = 0. frame_clk history register = 0.
  - Reset asserted mid-game takes effect immediately. No pending increment survives it.
- Frame tick: tick = frame_clk & ~frame_prev. frame_prev is registered every cycle. The tick is exactly one Clk cycle wide.
- FSM transitions, all registered:
  - IDLE: start=1 -> PLAYING.
  - PLAYING: dead=1 -> DEAD. dead has priority over start in the same cycle.
  - DEAD: start=1 -> PLAYING.
- Score clearing:
  - Any entry into PLAYING clears score1, score2, ones and tens in the same edge as the state change.
  - The arm flags are recomputed on the first tick after entry.
- Pass detection, only on a tick while in PLAYING, evaluated independently for pipe i:
  - ahead_i = ({1'b0,pipe_i_x} + PIPE_W) >= {1'b0,bird_x}. This is an 11-bit compare with no wrap.
  - If ahead_i: set arm_i = 1.
  - Else if arm_i = 1: raise inc_i and clear arm_i.
  - Else: no change.
  - Result: one increment per pipe per crossing. A pipe wrapping back to the right re-arms it.
- Increment rules:
  - score_i <= score_i + 1 on the edge after the tick, so score latency is 1 cycle from the tick.
  - Saturation: if the current total equals MAX_SCORE, inc_i is discarded and arm_i is still cleared.
  - If both inc_1 and inc_2 fire and total = MAX_SCORE - 1, only pipe 1 increments.
  - If both fire and total < MAX_SCORE - 1, both increment in the same edge and the total rises by 2.
- BCD counter, updated in the same edge as the score increment, never recomputed by division:
  - +1: ones 9 wraps to 0 with a carry into tens; otherwise ones + 1.
  - +2: ones 8 -> 0 and ones 9 -> 1, each with a carry; otherwise ones + 2.
  - Invariant every cycle: tens*10 + ones == score1 + score2.
- Ticks outside PLAYING are ignored: scores, BCD and arm flags hold.
- High score:
  - On the PLAYING->DEAD edge, if score1 + score2 > high_score then high_score <= score1 + score2. Otherwise it holds.
  - Cleared only by Reset. start does not clear it.
- A dead pulse and a pass tick in the same cycle: the increment from that tick is applied first. high_score then compares against the pre-increment total, since the compare uses current registers.
- dead held high while in DEAD has no effect. start held high while in PLAYING has no effect.

Test Plan:
- Reset, start=1 for 1 cycle, bird_x=100, pipe1_x=200, then step pipe1_x down 5 per tick to 35 -> state 01. score1 goes 0->1 exactly one cycle after the first tick with pipe1_x+60 < 100 (pipe1_x = 35). ones=1, tens=0. Further ticks with pipe1_x < 40 keep score1 at 1.
- Preload a total of 9 via nine pipe-1 passes, then one pipe-2 pass -> score2=1, ones=0, tens=1. Then both pipes pass on the same tick -> total 12, ones=2, tens=1.
- Drive the total to 98, then both pipes pass on the same tick -> score1 increments, score2 holds, ones=9, tens=9. A further pass leaves all outputs unchanged.
- Total 7, dead=1 -> state 10, high_score=7. Restart with start=1 -> scores 0, high_score 7. Reach total 3 and die -> high_score stays 7.
- In PLAYING with total 5, assert dead and start in the same cycle -> state 10, no clear, high_score=5.
- Assert Reset low mid-game, asynchronously between Clk edges, at total 42 -> all outputs 0 and state 00 before the next edge. After release, ticks without start leave scores 0.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper
//    Producer side of the score interface. Tracks the game state, detects
//    the bird clearing each pipe on frame ticks, and keeps per-pipe scores,
//    a BCD copy of the total and the session high score.
//
// Ports
//    Clk         in   system (pixel) clock
//    Reset       in   asynchronous active-low reset
//    frame_clk   in   vsync-rate level, its rising edge is the frame tick
//    start       in   start / restart request
//    dead        in   collision indication
//    bird_x      in   bird left-edge X
//    pipe1_x     in   pipe 1 left-edge X
//    pipe2_x     in   pipe 2 left-edge X
//    score1      out  pipes cleared via pipe 1
//    score2      out  pipes cleared via pipe 2
//    ones        out  BCD ones digit of score1 + score2
//    tens        out  BCD tens digit of score1 + score2
//    high_score  out  best total this power-on session
//    game_state  out  IDLE = 00, PLAYING = 01, DEAD = 10

module score_keeper #(
   parameter logic [9:0] PIPE_W    = 10'd60,
   parameter logic [6:0] MAX_SCORE = 7'd99
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       start,
   input  logic       dead,
   input  logic [9:0] bird_x,
   input  logic [9:0] pipe1_x,
   input  logic [9:0] pipe2_x,
   output logic [6:0] score1,
   output logic [6:0] score2,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic [6:0] high_score,
   output logic [1:0] game_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PLAYING = 2'b01,
      DEAD    = 2'b10
   } state_t;

   state_t     r_state;
   logic       r_framePrev;
   logic       r_arm1;
   logic       r_arm2;
   logic [6:0] r_score1;
   logic [6:0] r_score2;
   logic [3:0] r_ones;
   logic [3:0] r_tens;
   logic [6:0] r_highScore;

   logic       w_tick;
   logic       w_evalPass;
   logic       w_ahead1;
   logic       w_ahead2;
   logic       w_inc1;
   logic       w_inc2;
   logic [7:0] w_total;
   logic [7:0] w_max;
   logic       w_add1;
   logic       w_add2;
   logic [1:0] w_step;
   logic [3:0] w_onesNext;
   logic [3:0] w_tensNext;

   assign w_tick     = frame_clk & ~r_framePrev;
   assign w_evalPass = w_tick && (r_state == PLAYING);

   // Widened to 11 bits so a pipe near the right edge cannot wrap past the bird.
   assign w_ahead1 = ({1'b0, pipe1_x} + {1'b0, PIPE_W}) >= {1'b0, bird_x};
   assign w_ahead2 = ({1'b0, pipe2_x} + {1'b0, PIPE_W}) >= {1'b0, bird_x};

   assign w_inc1 = w_evalPass & ~w_ahead1 & r_arm1;
   assign w_inc2 = w_evalPass & ~w_ahead2 & r_arm2;

   assign w_total = {1'b0, r_score1} + {1'b0, r_score2};
   assign w_max   = {1'b0, MAX_SCORE};

   // Saturating arbitration: pipe 1 wins the last point when only one fits.
   always_comb begin
      w_add1 = 1'b0;
      w_add2 = 1'b0;
      if (w_inc1 && w_inc2) begin
         if ((w_total + 8'd2) <= w_max) begin
            w_add1 = 1'b1;
            w_add2 = 1'b1;
         end else if (w_total < w_max) begin
            w_add1 = 1'b1;
         end
      end else if (w_inc1 && (w_total < w_max)) begin
         w_add1 = 1'b1;
      end else if (w_inc2 && (w_total < w_max)) begin
         w_add2 = 1'b1;
      end
   end

   assign w_step = {1'b0, w_add1} + {1'b0, w_add2};

   // BCD digits advance alongside the binary scores so no divider is needed.
   always_comb begin
      w_onesNext = r_ones;
      w_tensNext = r_tens;
      case (w_step)
         2'd1: begin
            if (r_ones == 4'd9) begin
               w_onesNext = 4'd0;
               w_tensNext = r_tens + 4'd1;
            end else begin
               w_onesNext = r_ones + 4'd1;
            end
         end
         2'd2: begin
            if (r_ones >= 4'd8) begin
               w_onesNext = r_ones - 4'd8;
               w_tensNext = r_tens + 4'd1;
            end else begin
               w_onesNext = r_ones + 4'd2;
            end
         end
         default: begin
            w_onesNext = r_ones;
            w_tensNext = r_tens;
         end
      endcase
   end

   // State machine, pass arming and score registers. Entry into PLAYING is
   // written last so its clear overrides any score update in the same edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state     <= IDLE;
         r_framePrev <= 1'b0;
         r_arm1      <= 1'b0;
         r_arm2      <= 1'b0;
         r_score1    <= 7'd0;
         r_score2    <= 7'd0;
         r_ones      <= 4'd0;
         r_tens      <= 4'd0;
         r_highScore <= 7'd0;
      end else begin
         r_framePrev <= frame_clk;

         if (w_evalPass) begin
            if (w_ahead1)
               r_arm1 <= 1'b1;
            else if (r_arm1)
               r_arm1 <= 1'b0;
            if (w_ahead2)
               r_arm2 <= 1'b1;
            else if (r_arm2)
               r_arm2 <= 1'b0;
         end

         if (w_add1)
            r_score1 <= r_score1 + 7'd1;
         if (w_add2)
            r_score2 <= r_score2 + 7'd1;
         r_ones <= w_onesNext;
         r_tens <= w_tensNext;

         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state  <= PLAYING;
                  r_arm1   <= 1'b0;
                  r_arm2   <= 1'b0;
                  r_score1 <= 7'd0;
                  r_score2 <= 7'd0;
                  r_ones   <= 4'd0;
                  r_tens   <= 4'd0;
               end
            end
            PLAYING: begin
               // High score uses the pre-increment total of this edge.
               if (dead) begin
                  r_state <= DEAD;
                  if (w_total > {1'b0, r_highScore})
                     r_highScore <= w_total[6:0];
               end
            end
            DEAD: begin
               if (start) begin
                  r_state  <= PLAYING;
                  r_arm1   <= 1'b0;
                  r_arm2   <= 1'b0;
                  r_score1 <= 7'd0;
                  r_score2 <= 7'd0;
                  r_ones   <= 4'd0;
                  r_tens   <= 4'd0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign score1     = r_score1;
   assign score2     = r_score2;
   assign ones       = r_ones;
   assign tens       = r_tens;
   assign high_score = r_highScore;
   assign game_state = r_state;

endmodule
